bloom_filter_query: RTL and testbench

Membership-query stage for the Bloom filter. Accepts a 72-bit key over a valid/ready handshake and computes the seven 11-bit hash addresses with the shared `bloom_filter_hashes_11bit` module. It then probes the filter BRAM on a dedicated read port and returns hit/miss over a second valid/ready handshake. It sits downstream of the insert engine, consuming the bit array that engine fills, and keeps saturating query and hit statistics.

---
 rtl/bloom_filter_query.sv | 147 ++++++++++++++
 tb/tb_bloom_filter_query.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_filter_query.sv
// rtl/bloom_filter_query.sv - Bloom filter membership query: hash, probe BRAM rows, report hit/miss
module bloom_filter_hashes_11bit (
    input  logic [71:0]       key,
    output logic [6:0][10:0]  hashes
);
    logic [76:0] padded;

    assign padded = {5'b0, key};

    // Each address mixes two neighbouring 11-bit key slices so every key bit feeds two probes.
    for (genvar i = 0; i < 7; i++) begin : g_hash
        assign hashes[i] = padded[11*i +: 11] ^ padded[11*((i+1)%7) +: 11];
    end
endmodule

module bloom_filter_query #(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic [71:0]       key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              result_valid,
    output logic              result_hit,
    input  logic              result_ready,
    output logic              busy,
    output logic              enb,
    output logic [10:0]       addrb,
    input  logic [2047:0]     doutb,
    output logic [CNT_W-1:0]  query_count,
    output logic [CNT_W-1:0]  hit_count
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam logic [1:0] WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    state_t           state;
    state_t           state_nxt;
    logic [71:0]      key_reg;
    logic [2:0]       k;
    logic [1:0]       wait_cnt;
    logic [6:0][10:0] hashes;
    logic [10:0]      hash_k;
    logic             row_set;

    bloom_filter_hashes_11bit u_hashes (
        .key    (key_reg),
        .hashes (hashes)
    );

    always_comb begin
        hash_k = '0;
        case (k)
            3'd0:    hash_k = hashes[0];
            3'd1:    hash_k = hashes[1];
            3'd2:    hash_k = hashes[2];
            3'd3:    hash_k = hashes[3];
            3'd4:    hash_k = hashes[4];
            3'd5:    hash_k = hashes[5];
            3'd6:    hash_k = hashes[6];
            default: hash_k = '0;
        endcase
    end

    assign row_set = |doutb;

    always_comb begin
        state_nxt    = state;
        key_ready    = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        enb          = 1'b0;
        addrb        = '0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                busy      = 1'b0;
                if (key_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                enb       = 1'b1;
                addrb     = hash_k;
                state_nxt = (READ_LATENCY == 1) ? CHECK : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 2'd0) state_nxt = CHECK;
            end
            CHECK: begin
                // A clear row proves absence, so the remaining probes are skipped.
                if (!row_set || k == 3'd6) state_nxt = RESULT;
                else                       state_nxt = ISSUE;
            end
            RESULT: begin
                result_valid = 1'b1;
                if (result_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            key_reg     <= '0;
            k           <= '0;
            wait_cnt    <= '0;
            result_hit  <= 1'b0;
            query_count <= '0;
            hit_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        key_reg <= key_in;
                        k       <= '0;
                    end
                end
                ISSUE: wait_cnt <= WAIT_INIT;
                WAIT:  wait_cnt <= wait_cnt - 2'd1;
                CHECK: begin
                    if (!row_set)          result_hit <= 1'b0;
                    else if (k == 3'd6)    result_hit <= 1'b1;
                    else                   k <= k + 3'd1;
                end
                RESULT: begin
                    if (result_ready) begin
                        if (query_count != '1)              query_count <= query_count + CNT_W'(1);
                        if (result_hit && hit_count != '1)  hit_count   <= hit_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bloom_filter_query.sv
// tb/tb_bloom_filter_query.sv - directed checks of bloom_filter_query at latency 1 and 3
module tb_bloom_filter_query;
    localparam logic [71:0] KEY1 = 72'h0123456789ABCDEF01;

    logic clka = 1'b0;
    logic rst_n = 1'b0;

    logic [71:0]   key_a = '0, key_b = '0;
    logic          kv_a = 0, kv_b = 0, rr_a = 0, rr_b = 0;
    logic          kr_a, kr_b, rv_a, rv_b, rh_a, rh_b, busy_a, busy_b, enb_a, enb_b;
    logic [10:0]   addrb_a, addrb_b;
    logic [2047:0] doutb_a = '0, doutb_b = '0, st1_b = '0, st2_b = '0;
    logic [15:0]   qc_a, hc_a;
    logic [3:0]    qc_b, hc_b;

    bit            row_set_a [0:2047];
    bit            row_set_b [0:2047];
    bit            wide_rows = 1'b0;
    logic [10:0]   addr_q_a [$];
    logic [10:0]   addr_q_b [$];
    logic [10:0]   exp_hash [7] = '{11'h6BC, 11'h712, 11'h56B, 11'h792, 11'h610, 11'h246, 11'h701};

    int errors = 0;
    int checks = 0;

    always #5 clka = ~clka;

    bloom_filter_query #(.READ_LATENCY(1), .CNT_W(16)) u_dut_a (
        .clka(clka), .rst_n(rst_n), .key_in(key_a), .key_valid(kv_a), .key_ready(kr_a),
        .result_valid(rv_a), .result_hit(rh_a), .result_ready(rr_a), .busy(busy_a),
        .enb(enb_a), .addrb(addrb_a), .doutb(doutb_a), .query_count(qc_a), .hit_count(hc_a)
    );

    bloom_filter_query #(.READ_LATENCY(3), .CNT_W(4)) u_dut_b (
        .clka(clka), .rst_n(rst_n), .key_in(key_b), .key_valid(kv_b), .key_ready(kr_b),
        .result_valid(rv_b), .result_hit(rh_b), .result_ready(rr_b), .busy(busy_b),
        .enb(enb_b), .addrb(addrb_b), .doutb(doutb_b), .query_count(qc_b), .hit_count(hc_b)
    );

    function automatic logic [2047:0] row_word(input bit set, input logic [10:0] a);
        logic [2047:0] w;
        w = '0;
        if (set) begin
            if (wide_rows) w = '1;
            else           w[a] = 1'b1;
        end
        return w;
    endfunction

    // Read data is non-zero only exactly READ_LATENCY edges after an enabled read.
    always @(posedge clka) begin
        doutb_a <= enb_a ? row_word(row_set_a[addrb_a], addrb_a) : '0;
        st1_b   <= enb_b ? row_word(row_set_b[addrb_b], addrb_b) : '0;
        st2_b   <= st1_b;
        doutb_b <= st2_b;
    end

    always @(negedge clka) begin
        if (enb_a) addr_q_a.push_back(addrb_a);
        if (enb_b) addr_q_b.push_back(addrb_b);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_query(input bit sel, input logic [71:0] key, output int lat, output logic hit);
        @(negedge clka);
        if (sel) begin key_b = key; kv_b = 1; rr_b = 1; end
        else     begin key_a = key; kv_a = 1; rr_a = 1; end
        check_eq("key_ready_before_accept", sel ? kr_b : kr_a, 1);
        @(posedge clka);
        @(negedge clka);
        if (sel) kv_b = 0; else kv_a = 0;
        lat = 0;
        while (!(sel ? rv_b : rv_a) && lat < 200) begin
            @(posedge clka);
            lat++;
            @(negedge clka);
        end
        lat = lat + 1;
        hit = sel ? rh_b : rh_a;
        @(posedge clka);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   n;
        int   bad;
        logic hit;
        logic h0;

        for (int i = 0; i < 2048; i++) begin
            row_set_a[i] = 1'b1;
            row_set_b[i] = 1'b1;
        end

        #3;
        check_eq("rst_key_ready", kr_a, 1);
        check_eq("rst_result_valid", rv_a, 0);
        check_eq("rst_result_hit", rh_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_enb", enb_a, 0);
        check_eq("rst_addrb", addrb_a, 0);
        check_eq("rst_counts", {qc_a, hc_a}, 0);
        repeat (3) @(negedge clka);
        rst_n = 1'b1;

        // All rows all-ones: seven probes in hash order, then a hit.
        wide_rows = 1'b1;
        addr_q_a.delete();
        run_query(0, KEY1, lat, hit);
        @(negedge clka);
        check_eq("allset_latency", lat, 15);
        check_eq("allset_hit", hit, 1);
        check_eq("allset_enb_pulses", addr_q_a.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < addr_q_a.size()) check_eq($sformatf("allset_addr%0d", i), addr_q_a[i], exp_hash[i]);
        check_eq("allset_query_count", qc_a, 1);
        check_eq("allset_hit_count", hc_a, 1);
        wide_rows = 1'b0;

        // Clearing the row at hash_2 stops the query after the third probe.
        row_set_a[11'h56B] = 1'b0;
        addr_q_a.delete();
        run_query(0, KEY1, lat, hit);
        @(negedge clka);
        check_eq("miss_latency", lat, 7);
        check_eq("miss_hit", hit, 0);
        check_eq("miss_enb_pulses", addr_q_a.size(), 3);
        check_eq("miss_query_count", qc_a, 2);
        check_eq("miss_hit_count", hc_a, 1);
        row_set_a[11'h56B] = 1'b1;

        // Backpressure with a second key waiting on key_valid.
        @(negedge clka);
        key_a = KEY1; kv_a = 1; rr_a = 0;
        @(posedge clka);
        @(negedge clka);
        key_a = 72'h0;
        n = 0;
        while (!rv_a && n < 100) begin @(negedge clka); n++; end
        check_eq("bp_result_valid", rv_a, 1);
        check_eq("bp_result_hit", rh_a, 1);
        h0 = rh_a;
        bad = 0;
        repeat (20) begin
            @(negedge clka);
            if (rv_a !== 1'b1 || rh_a !== h0 || kr_a !== 1'b0 || enb_a !== 1'b0) bad++;
        end
        check_eq("bp_hold_stable", bad, 0);
        check_eq("bp_query_count_held", qc_a, 2);
        rr_a = 1;
        @(posedge clka);
        @(negedge clka);
        check_eq("bp_ready_after_handshake", kr_a, 1);
        check_eq("bp_valid_dropped", rv_a, 0);
        check_eq("bp_query_count", qc_a, 3);
        check_eq("bp_hit_count", hc_a, 2);
        @(posedge clka);
        @(negedge clka);
        kv_a = 0;
        check_eq("bp_second_issue_enb", enb_a, 1);
        check_eq("bp_second_issue_addr", addrb_a, 0);
        n = 0;
        while (!rv_a && n < 100) begin @(negedge clka); n++; end
        check_eq("bp_second_hit", rh_a, 1);
        @(posedge clka);
        @(negedge clka);
        check_eq("bp_second_query_count", qc_a, 4);

        // Reset during the fourth probe aborts the query at once.
        key_a = KEY1; kv_a = 1; rr_a = 1;
        @(posedge clka);
        @(negedge clka);
        kv_a = 0;
        n = 0;
        bad = 0;
        while (n < 100) begin
            if (enb_a) bad++;
            if (bad == 4) break;
            @(negedge clka);
            n++;
        end
        check_eq("abort_probe3_addr", addrb_a, 11'h792);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_key_ready", kr_a, 1);
        check_eq("abort_enb", enb_a, 0);
        check_eq("abort_addrb", addrb_a, 0);
        check_eq("abort_busy", busy_a, 0);
        check_eq("abort_valid_hit", {rv_a, rh_a}, 0);
        check_eq("abort_counts", {qc_a, hc_a}, 0);
        repeat (2) @(posedge clka);
        @(negedge clka);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clka);
            if (kr_a !== 1'b1 || rv_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        check_eq("post_reset_idle", bad, 0);
        check_eq("post_reset_counts", {qc_a, hc_a}, 0);

        // Latency 3: CHECK must see data exactly three edges after ISSUE.
        addr_q_b.delete();
        run_query(1, KEY1, lat, hit);
        @(negedge clka);
        check_eq("lat3_latency", lat, 29);
        check_eq("lat3_hit", hit, 1);
        check_eq("lat3_enb_pulses", addr_q_b.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < addr_q_b.size()) check_eq($sformatf("lat3_addr%0d", i), addr_q_b[i], exp_hash[i]);
        check_eq("lat3_query_count", qc_b, 1);

        // Sixteen more hits drive the 4-bit counters into saturation.
        bad = 0;
        for (int q = 0; q < 16; q++) begin
            run_query(1, KEY1 ^ 72'(q), lat, hit);
            if (hit !== 1'b1) bad++;
        end
        @(negedge clka);
        check_eq("sat_all_hit", bad, 0);
        check_eq("sat_query_count", qc_b, 4'hF);
        check_eq("sat_hit_count", hc_b, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
